// File: rtl/reorder_test_pkg.sv
// Shared types for the remote-node reorder test fabric.
// Latency: n/a (types and default sizes only).
// Backpressure: n/a.
// Contents: default payload width, node count and tag pool size, plus the
// tagged request layout {tag, payload} seen by the remote nodes and the
// reorder buffer.
package reorder_test_pkg;

  localparam int req_width_lp     = 32;
  localparam int req_nodes_lp     = 4;
  localparam int req_els_lp       = 8;
  localparam int req_tag_width_lp = $clog2(req_els_lp);

  typedef struct packed {
    logic [req_tag_width_lp-1:0] tag;
    logic [req_width_lp-1:0]     payload;
  } tagged_req_t;

endpackage

// File: rtl/bsg_circular_ptr.sv
// Circular pointer over slots_p slots, advancing by one when add_i is high.
// Latency: o reflects an add on the clock edge after add_i.
// Backpressure: none; the owner decides when to add.
// Ports: clk_i, reset_n_i (async, active low), add_i, o (current slot).
module bsg_circular_ptr #(
  parameter int slots_p = 4,
  localparam int ptr_width_lp = (slots_p > 1) ? $clog2(slots_p) : 1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    add_i,
  output logic [ptr_width_lp-1:0] o
);

  logic [ptr_width_lp-1:0] ptr_q, ptr_d;

  // Explicit wrap so non-power-of-two slot counts work as well.
  always_comb begin
    ptr_d = ptr_q;
    if (add_i) begin
      if (ptr_q == ptr_width_lp'(slots_p - 1)) ptr_d = '0;
      else                                     ptr_d = ptr_q + ptr_width_lp'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) ptr_q <= '0;
    else            ptr_q <= ptr_d;
  end

  assign o = ptr_q;

endmodule

// File: rtl/reorder_tag_dispatcher.sv
// Tags in-order requests from a pool of els_p tags and sprays them round-robin
// to num_nodes_p remote nodes; checks in-order tag retirement.
// Latency: 1 cycle accept -> node_v_o. Backpressure: ready_o drops while the
// staged request is not taken or all els_p tags are outstanding.
// Ports: clk_i/reset_n_i; upstream v_i/data_i/ready_o; node_v_o (one-hot),
// node_data_o {tag,payload}, node_yumi_i; dealloc_v_i/dealloc_tag_i;
// outstanding_o (tags in flight); error_o (sticky protocol error).
module reorder_tag_dispatcher
  import reorder_test_pkg::*;
#(
  parameter int width_p     = req_width_lp,
  parameter int num_nodes_p = req_nodes_lp,
  parameter int els_p       = req_els_lp,
  localparam int lg_els_lp   = $clog2(els_p),
  localparam int lg_nodes_lp = $clog2(num_nodes_p)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         v_i,
  input  logic [width_p-1:0]           data_i,
  output logic                         ready_o,
  output logic [num_nodes_p-1:0]       node_v_o,
  output logic [lg_els_lp+width_p-1:0] node_data_o,
  input  logic [num_nodes_p-1:0]       node_yumi_i,
  input  logic                         dealloc_v_i,
  input  logic [lg_els_lp-1:0]         dealloc_tag_i,
  output logic [lg_els_lp:0]           outstanding_o,
  output logic                         error_o
);

  logic                   v_q, v_d;
  logic [lg_els_lp-1:0]   tag_q, tag_d;
  logic [width_p-1:0]     data_q, data_d;
  logic [lg_els_lp:0]     cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic [lg_els_lp-1:0]   wr_ptr, rd_ptr;
  logic [lg_nodes_lp-1:0] rr;

  logic fire, accept, pool_full, cnt_zero, dealloc_ok, yumi_err;

  assign pool_full  = (cnt_q == (lg_els_lp+1)'(els_p));
  assign cnt_zero   = (cnt_q == '0);
  assign fire       = v_q & node_yumi_i[rr];
  // Registered count only: a dealloc this cycle does not open the pool yet.
  assign ready_o    = reset_n_i & ~pool_full & (~v_q | fire);
  assign accept     = v_i & ready_o;
  // A dealloc with nothing in flight is an error and retires nothing.
  assign dealloc_ok = dealloc_v_i & ~cnt_zero;

  assign node_v_o    = v_q ? (num_nodes_p'(1) << rr) : '0;
  assign node_data_o = v_q ? {tag_q, data_q} : '0;
  assign yumi_err    = |(node_yumi_i & ~node_v_o);

  bsg_circular_ptr #(.slots_p(els_p)) wr_ptr_u (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .add_i(accept), .o(wr_ptr)
  );

  // The expected retire pointer advances even on a tag mismatch.
  bsg_circular_ptr #(.slots_p(els_p)) rd_ptr_u (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .add_i(dealloc_ok), .o(rd_ptr)
  );

  // Rotates on every offered cycle so a stalled node is skipped next cycle.
  bsg_circular_ptr #(.slots_p(num_nodes_p)) rr_u (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .add_i(v_q), .o(rr)
  );

  always_comb begin
    v_d    = v_q;
    tag_d  = tag_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    err_d  = err_q;

    if (accept) begin
      v_d    = 1'b1;
      tag_d  = wr_ptr;
      data_d = data_i;
    end else if (fire) begin
      v_d = 1'b0;
    end

    case ({accept, dealloc_ok})
      2'b10:   cnt_d = cnt_q + (lg_els_lp+1)'(1);
      2'b01:   cnt_d = cnt_q - (lg_els_lp+1)'(1);
      default: cnt_d = cnt_q;
    endcase

    if ((dealloc_v_i & cnt_zero) |
        (dealloc_v_i & (dealloc_tag_i != rd_ptr)) |
        yumi_err)
      err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_q    <= 1'b0;
      tag_q  <= '0;
      data_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      v_q    <= v_d;
      tag_q  <= tag_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign outstanding_o = cnt_q;
  assign error_o       = err_q;

endmodule

// File: tb/tb_reorder_tag_dispatcher.sv
// Randomized and directed bench for reorder_tag_dispatcher (default sizes:
// 32-bit payload, 4 nodes, 8 tags). A queue-based model of tags in flight
// predicts every output; a few literal checks pin the model's behaviour.
module tb_reorder_tag_dispatcher;
  import reorder_test_pkg::*;

  localparam int NN = 4;
  localparam int EL = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v_i = 1'b0;
  logic [31:0] data_i = '0;
  logic        ready_o;
  logic [3:0]  node_v_o;
  logic [34:0] node_data_o;
  logic [3:0]  node_yumi_i = '0;
  logic        dealloc_v_i = 1'b0;
  logic [2:0]  dealloc_tag_i = '0;
  logic [3:0]  outstanding_o;
  logic        error_o;

  int total = 0;
  int bad = 0;

  reorder_tag_dispatcher dut (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i), .data_i(data_i),
    .ready_o(ready_o), .node_v_o(node_v_o), .node_data_o(node_data_o),
    .node_yumi_i(node_yumi_i), .dealloc_v_i(dealloc_v_i),
    .dealloc_tag_i(dealloc_tag_i), .outstanding_o(outstanding_o),
    .error_o(error_o)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Tags in flight are a FIFO of issued tags; tag number = issue count mod EL;
  // the node offered is (number of cycles something was staged) mod NN.
  int          inflight[$];
  int          m_issued = 0;
  int          m_offers = 0;
  logic        m_stg_v = 1'b0;
  logic [2:0]  m_stg_tag = '0;
  logic [31:0] m_stg_dat = '0;
  logic        m_err = 1'b0;

  function automatic logic [3:0] m_node_v();
    logic [3:0] one;
    one = 4'd1;
    return m_stg_v ? (one << (m_offers % NN)) : 4'd0;
  endfunction

  function automatic logic m_fire();
    return m_stg_v && node_yumi_i[m_offers % NN];
  endfunction

  function automatic logic m_ready();
    return rst_n && (inflight.size() != EL) && (!m_stg_v || m_fire());
  endfunction

  function automatic logic [34:0] m_node_data();
    return m_stg_v ? {m_stg_tag, m_stg_dat} : 35'd0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight.delete();
      m_issued = 0; m_offers = 0; m_stg_v = 1'b0;
      m_stg_tag = '0; m_stg_dat = '0; m_err = 1'b0;
    end else begin
      logic acc, fir;
      acc = v_i && m_ready();
      fir = m_fire();
      if ((node_yumi_i & ~m_node_v()) != 4'd0) m_err = 1'b1;
      if (dealloc_v_i) begin
        if (inflight.size() == 0) m_err = 1'b1;
        else begin
          if (int'(dealloc_tag_i) != inflight[0]) m_err = 1'b1;
          void'(inflight.pop_front());
        end
      end
      if (m_stg_v) m_offers++;
      if (acc) begin
        m_stg_v = 1'b1;
        m_stg_tag = 3'(m_issued % EL);
        m_stg_dat = data_i;
        inflight.push_back(m_issued % EL);
        m_issued++;
      end else if (fir) begin
        m_stg_v = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Single compare process: every cycle, away from the clock edge.
  always @(negedge clk) begin
    #2;
    chk("ready_o", 64'(ready_o), 64'(m_ready()));
    chk("node_v_o", 64'(node_v_o), 64'(m_node_v()));
    chk("node_data_o", 64'(node_data_o), 64'(m_node_data()));
    chk("outstanding_o", 64'(outstanding_o), 64'(inflight.size()));
    chk("error_o", 64'(error_o), 64'(m_err));
  end

  // ---------------- stimulus ----------------
  // ymode: 0 none, 1 yumi offered node, 2 same but node 1 never, 3 random, 4 mask
  // dmode: 0 none, 1 retire oldest tag, 2 retire oldest 50%, 3 explicit tag
  task automatic cycle(input logic v, input logic [31:0] d, input int ymode,
                       input logic [3:0] ymask, input int dmode, input logic [2:0] dt);
    @(negedge clk);
    v_i = v;
    data_i = d;
    case (ymode)
      0: node_yumi_i = 4'd0;
      1: node_yumi_i = m_node_v();
      2: node_yumi_i = ((m_offers % NN) == 1) ? 4'd0 : m_node_v();
      3: node_yumi_i = ($urandom_range(0, 1) == 1) ? m_node_v() : 4'd0;
      default: node_yumi_i = ymask;
    endcase
    dealloc_v_i = 1'b0;
    dealloc_tag_i = '0;
    if ((dmode == 1 || (dmode == 2 && $urandom_range(0, 1) == 1)) && inflight.size() > 0) begin
      dealloc_v_i = 1'b1;
      dealloc_tag_i = 3'(inflight[0]);
    end else if (dmode == 3) begin
      dealloc_v_i = 1'b1;
      dealloc_tag_i = dt;
    end
    #1;
  endtask

  task automatic idle(input int ymode);
    cycle(1'b0, 32'd0, ymode, 4'd0, 0, 3'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(0);
    idle(0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int log_node[$];
  int log_tag[$];

  task automatic log_fire();
    tagged_req_t r;
    if ((node_v_o & node_yumi_i) != 4'd0) begin
      r = node_data_o;
      for (int i = 0; i < NN; i++)
        if (node_v_o[i]) log_node.push_back(i);
      log_tag.push_back(int'(r.tag));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_n, n1_offers, fires;
    tagged_req_t r;

    // Reset state
    do_reset();
    idle(0);
    chk("reset_ready", 64'(ready_o), 64'd1);
    chk("reset_outstanding", 64'(outstanding_o), 64'd0);

    // 1: async reset with a request staged
    cycle(1'b1, 32'hA5A5_0001, 0, 4'd0, 0, 3'd0);
    idle(0);
    chk("t1_staged_node_v", 64'(node_v_o), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_rst_node_v", 64'(node_v_o), 64'd0);
    chk("t1_rst_ready", 64'(ready_o), 64'd0);
    chk("t1_rst_data", 64'(node_data_o), 64'd0);
    idle(0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 32'h1234_5678, 0, 4'd0, 0, 3'd0);
    idle(1);
    chk("t1_after_node_v", 64'(node_v_o), 64'd1);
    chk("t1_after_data", 64'(node_data_o), {29'd0, 3'd0, 32'h1234_5678});
    idle(1);

    // 2: eight requests, each node yumis as soon as offered, no dealloc
    do_reset();
    log_node.delete(); log_tag.delete();
    acc_n = 0;
    for (int c = 0; c < 40 && log_tag.size() < 8; c++) begin
      cycle(acc_n < 8, $urandom, 1, 4'd0, 0, 3'd0);
      if (v_i && m_ready()) acc_n++;
      log_fire();
    end
    chk("t2_fire_count", 64'(log_tag.size()), 64'd8);
    for (int i = 0; i < 8 && i < log_tag.size(); i++) begin
      chk("t2_node", 64'(log_node[i]), 64'(i % 4));
      chk("t2_tag", 64'(log_tag[i]), 64'(i));
    end
    idle(0);
    chk("t2_full_ready", 64'(ready_o), 64'd0);
    chk("t2_outstanding", 64'(outstanding_o), 64'd8);

    // 3: retire tag 0 -> ready next cycle only, 9th request wraps to tag 0
    cycle(1'b0, 32'd0, 0, 4'd0, 3, 3'd0);
    chk("t3_same_cycle_ready", 64'(ready_o), 64'd0);
    cycle(1'b1, 32'hCAFE_0009, 0, 4'd0, 0, 3'd0);
    chk("t3_next_ready", 64'(ready_o), 64'd1);
    log_node.delete(); log_tag.delete();
    idle(1);
    log_fire();
    chk("t3_wrap_fired", 64'(log_tag.size()), 64'd1);
    if (log_tag.size() > 0) begin
      chk("t3_wrap_tag", 64'(log_tag[0]), 64'd0);
      chk("t3_wrap_node", 64'(log_node[0]), 64'd0);
    end

    // 4: node 1 never yumis
    do_reset();
    log_node.delete(); log_tag.delete();
    n1_offers = 0;
    for (int c = 0; c < 60; c++) begin
      cycle(1'b1, $urandom, 2, 4'd0, 1, 3'd0);
      if (node_v_o == 4'b0010) n1_offers++;
      log_fire();
    end
    fires = 0;
    foreach (log_node[i]) if (log_node[i] == 1) fires++;
    chk("t4_node1_fires", 64'(fires), 64'd0);
    chk("t4_node1_offered", 64'(n1_offers > 0), 64'd1);
    chk("t4_progress", 64'(log_tag.size() > 20), 64'd1);
    chk("t4_no_error", 64'(error_o), 64'd0);

    // 5: accept and dealloc together at outstanding 3
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1, 4'd0, 0, 3'd0);
    idle(1);
    idle(1);
    chk("t5_before", 64'(outstanding_o), 64'd3);
    cycle(1'b1, $urandom, 1, 4'd0, 1, 3'd0);
    chk("t5_both_ready", 64'(ready_o), 64'd1);
    idle(1);
    chk("t5_after", 64'(outstanding_o), 64'd3);

    // 6a: wrong tag retired
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1, 4'd0, 0, 3'd0);
    idle(1);
    idle(1);
    cycle(1'b0, 32'd0, 0, 4'd0, 3, 3'd2);
    chk("t6a_err_same_cycle", 64'(error_o), 64'd0);
    idle(0);
    chk("t6a_err", 64'(error_o), 64'd1);
    for (int i = 0; i < 3; i++) idle(0);
    chk("t6a_sticky", 64'(error_o), 64'd1);
    do_reset();
    idle(0);
    chk("t6a_cleared", 64'(error_o), 64'd0);

    // 6b: dealloc with nothing in flight
    cycle(1'b0, 32'd0, 0, 4'd0, 3, 3'd0);
    idle(0);
    chk("t6b_err", 64'(error_o), 64'd1);
    chk("t6b_outstanding", 64'(outstanding_o), 64'd0);

    // 6c: yumi on a node that is not being offered
    do_reset();
    cycle(1'b1, 32'h0000_00C6, 0, 4'd0, 0, 3'd0);
    cycle(1'b0, 32'd0, 4, 4'b0100, 0, 3'd0);
    idle(0);
    chk("t6c_err", 64'(error_o), 64'd1);

    // Randomized legal traffic
    do_reset();
    for (int c = 0; c < 3000; c++)
      cycle(1'($urandom_range(0, 1)), $urandom, 3, 4'd0, 2, 3'd0);
    idle(0);
    chk("rand_no_error", 64'(error_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
